// File: rtl/rf_wb_scheduler_if.sv
// Bundle of handshake and write-port signals between the issue/execute side
// and the write-back scheduler. The master modport is the environment that
// drives the requests. The slave modport is the scheduler itself.
interface rf_wb_scheduler_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  iss_valid;
  logic [ADDR_WIDTH-1:0] iss_rs1;
  logic [ADDR_WIDTH-1:0] iss_rs2;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic                  iss_ready;

  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  alu_ready;

  logic                  lsu_valid;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  lsu_ready;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_rd;
  logic [DATA_WIDTH-1:0] rf_wdata;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  iss_ready, alu_ready, lsu_ready,
    input  rf_wen, rf_rd, rf_wdata
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output iss_ready, alu_ready, lsu_ready,
    output rf_wen, rf_rd, rf_wdata
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler and hazard scoreboard for a 2R/1W register file.
// The ALU and LSU result streams share the single write port. One busy bit
// per register stalls issue on RAW and WAW hazards.
// Build option: define RF_WB_RR_ARB_EN for round-robin arbitration. Without
// it, the LSU has fixed priority over the ALU.
module rf_wb_scheduler #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  rf_wb_scheduler_if.slave bus
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0]       busy_q, busy_d;
  logic                  lastGrant_q, lastGrant_d;
  logic                  rfWen_q, rfWen_d;
  logic [ADDR_WIDTH-1:0] rfRd_q, rfRd_d;
  logic [DATA_WIDTH-1:0] rfWdata_q, rfWdata_d;

  logic hazard;
  logic issueFire;
  logic aluGrant;
  logic lsuGrant;

  // The hazard check reads registered busy state only, so the stall path is short.
  always_comb begin
    hazard    = busy_q[bus.iss_rs1] | busy_q[bus.iss_rs2] | busy_q[bus.iss_rd];
    issueFire = bus.iss_valid & ~hazard & (bus.iss_rd != '0);
  end

  // Arbitration depends on the valids and last_grant only. Data never reaches the ready outputs.
  always_comb begin
    aluGrant = 1'b0;
    lsuGrant = 1'b0;
    if (bus.alu_valid && bus.lsu_valid) begin
`ifdef RF_WB_RR_ARB_EN
      if (lastGrant_q) aluGrant = 1'b1;
      else             lsuGrant = 1'b1;
`else
      lsuGrant = 1'b1;
`endif
    end else if (bus.alu_valid) begin
      aluGrant = 1'b1;
    end else if (bus.lsu_valid) begin
      lsuGrant = 1'b1;
    end
  end

  // Next state: the write port, last_grant, and busy bits. A set wins over a clear on the same index.
  always_comb begin
    lastGrant_d = lastGrant_q;
    rfWen_d     = 1'b0;
    rfRd_d      = rfRd_q;
    rfWdata_d   = rfWdata_q;
    if (aluGrant) begin
      lastGrant_d = 1'b0;
      rfRd_d      = bus.alu_rd;
      rfWdata_d   = bus.alu_data;
      rfWen_d     = (bus.alu_rd != '0);
    end else if (lsuGrant) begin
      lastGrant_d = 1'b1;
      rfRd_d      = bus.lsu_rd;
      rfWdata_d   = bus.lsu_data;
      rfWen_d     = (bus.lsu_rd != '0);
    end

    busy_d = busy_q;
    if (rfWen_q)   busy_d[rfRd_q]      = 1'b0;
    if (issueFire) busy_d[bus.iss_rd]  = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers. An async reset abandons any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      lastGrant_q <= 1'b1;
      rfWen_q     <= 1'b0;
      rfRd_q      <= '0;
      rfWdata_q   <= '0;
    end else begin
      busy_q      <= busy_d;
      lastGrant_q <= lastGrant_d;
      rfWen_q     <= rfWen_d;
      rfRd_q      <= rfRd_d;
      rfWdata_q   <= rfWdata_d;
    end
  end

  assign bus.iss_ready = ~hazard;
  assign bus.alu_ready = aluGrant;
  assign bus.lsu_ready = lsuGrant;
  assign bus.rf_wen    = rfWen_q;
  assign bus.rf_rd     = rfRd_q;
  assign bus.rf_wdata  = rfWdata_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed testbench for rf_wb_scheduler. It covers reset, RAW and WAW stalls,
// write-port arbitration, x0 writes, and asynchronous reset during a write.
module tb_rf_wb_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rf_wb_scheduler_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  rf_wb_scheduler #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step to just after the next rising edge. Inputs are driven here.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.iss_valid = 1'b0; bus.iss_rs1 = '0; bus.iss_rs2 = '0; bus.iss_rd = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst_n = 1'b0;
    #3;
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen: got %b want 0", bus.rf_wen); end
    checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_iss_ready: got %b want 1", bus.iss_ready); end
    checks++; if (bus.alu_ready !== 1'b0 || bus.lsu_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_readys: got alu=%b lsu=%b want 0/0", bus.alu_ready, bus.lsu_ready); end
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    #1;
    checks++; if (bus.rf_wen !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_wdata !== 32'd0) begin errors++; $display("[TB] FAIL idle_port: got wen=%b rd=%0d data=%h want 0/0/0", bus.rf_wen, bus.rf_rd, bus.rf_wdata); end
    checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_iss_ready: got %b want 1", bus.iss_ready); end
  endtask

  task automatic test_raw();
    // cycle 0: issue rd=5
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5; bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd0;
    #1;
    checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("[TB] FAIL raw_issue: got %b want 1", bus.iss_ready); end
    // cycle 1: dependent read of r5
    nextCycle();
    bus.iss_rd = 5'd0; bus.iss_rs1 = 5'd5;
    #1;
    checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("[TB] FAIL raw_stall_c1: got %b want 0", bus.iss_ready); end
    nextCycle();
    // cycle 3: ALU writes r5
    nextCycle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #1;
    checks++; if (bus.alu_ready !== 1'b1 || bus.iss_ready !== 1'b0) begin errors++; $display("[TB] FAIL raw_grant_c3: got alu_ready=%b iss_ready=%b want 1/0", bus.alu_ready, bus.iss_ready); end
    // cycle 4: write visible, still stalled
    nextCycle();
    bus.alu_valid = 1'b0;
    #1;
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd5 || bus.rf_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL raw_write_c4: got wen=%b rd=%0d data=%h want 1/5/deadbeef", bus.rf_wen, bus.rf_rd, bus.rf_wdata); end
    checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("[TB] FAIL raw_stall_c4: got %b want 0", bus.iss_ready); end
    // cycle 5: hazard resolved
    nextCycle();
    #1;
    checks++; if (bus.iss_ready !== 1'b1 || bus.rf_wen !== 1'b0) begin errors++; $display("[TB] FAIL raw_release_c5: got iss_ready=%b wen=%b want 1/0", bus.iss_ready, bus.rf_wen); end
    nextCycle();
    idleInputs();
  endtask

  task automatic test_conflict();
    test_reset();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hAAAA0003;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'hBBBB0004;
    #1;
`ifdef RF_WB_RR_ARB_EN
    checks++; if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin errors++; $display("[TB] FAIL conflict_first: got alu=%b lsu=%b want 1/0", bus.alu_ready, bus.lsu_ready); end
    nextCycle();
    #1;
    checks++; if (bus.alu_ready !== 1'b0 || bus.lsu_ready !== 1'b1) begin errors++; $display("[TB] FAIL conflict_second: got alu=%b lsu=%b want 0/1", bus.alu_ready, bus.lsu_ready); end
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd3 || bus.rf_wdata !== 32'hAAAA0003) begin errors++; $display("[TB] FAIL conflict_write1: got wen=%b rd=%0d data=%h want 1/3/aaaa0003", bus.rf_wen, bus.rf_rd, bus.rf_wdata); end
    nextCycle();
    bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
    #1;
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd4 || bus.rf_wdata !== 32'hBBBB0004) begin errors++; $display("[TB] FAIL conflict_write2: got wen=%b rd=%0d data=%h want 1/4/bbbb0004", bus.rf_wen, bus.rf_rd, bus.rf_wdata); end
`else
    checks++; if (bus.alu_ready !== 1'b0 || bus.lsu_ready !== 1'b1) begin errors++; $display("[TB] FAIL conflict_first: got alu=%b lsu=%b want 0/1", bus.alu_ready, bus.lsu_ready); end
    nextCycle();
    bus.lsu_valid = 1'b0;
    #1;
    checks++; if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin errors++; $display("[TB] FAIL conflict_second: got alu=%b lsu=%b want 1/0", bus.alu_ready, bus.lsu_ready); end
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd4 || bus.rf_wdata !== 32'hBBBB0004) begin errors++; $display("[TB] FAIL conflict_write1: got wen=%b rd=%0d data=%h want 1/4/bbbb0004", bus.rf_wen, bus.rf_rd, bus.rf_wdata); end
    nextCycle();
    bus.alu_valid = 1'b0;
    #1;
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd3 || bus.rf_wdata !== 32'hAAAA0003) begin errors++; $display("[TB] FAIL conflict_write2: got wen=%b rd=%0d data=%h want 1/3/aaaa0003", bus.rf_wen, bus.rf_rd, bus.rf_wdata); end
`endif
    nextCycle();
    #1;
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("[TB] FAIL conflict_idle: got wen=%b want 0", bus.rf_wen); end
    idleInputs();
  endtask

  task automatic test_x0();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd0;
    #1;
    checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_issue: got %b want 1", bus.iss_ready); end
    nextCycle();
    #1;
    checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_not_busy: got %b want 1", bus.iss_ready); end
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h00001234;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_alu_ready: got %b want 1", bus.alu_ready); end
    nextCycle();
    bus.alu_valid = 1'b0;
    #1;
    checks++; if (bus.rf_wen !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_wdata !== 32'h00001234) begin errors++; $display("[TB] FAIL x0_suppressed: got wen=%b rd=%0d data=%h want 0/0/00001234", bus.rf_wen, bus.rf_rd, bus.rf_wdata); end
    checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("[TB] FAIL x0_ready_drop: got %b want 0", bus.alu_ready); end
    idleInputs();
  endtask

  task automatic test_waw();
    nextCycle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    #1;
    checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("[TB] FAIL waw_first: got %b want 1", bus.iss_ready); end
    nextCycle();
    #1;
    checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("[TB] FAIL waw_stall: got %b want 0", bus.iss_ready); end
    nextCycle();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'hCAFEF00D;
    #1;
    checks++; if (bus.lsu_ready !== 1'b1 || bus.iss_ready !== 1'b0) begin errors++; $display("[TB] FAIL waw_grant: got lsu_ready=%b iss_ready=%b want 1/0", bus.lsu_ready, bus.iss_ready); end
    nextCycle();
    bus.lsu_valid = 1'b0;
    #1;
    checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd7 || bus.rf_wdata !== 32'hCAFEF00D || bus.iss_ready !== 1'b0) begin errors++; $display("[TB] FAIL waw_write: got wen=%b rd=%0d data=%h iss_ready=%b want 1/7/cafef00d/0", bus.rf_wen, bus.rf_rd, bus.rf_wdata, bus.iss_ready); end
    nextCycle();
    #1;
    checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("[TB] FAIL waw_release: got %b want 1", bus.iss_ready); end
    nextCycle();
    bus.iss_valid = 1'b0; bus.iss_rd = 5'd0; bus.iss_rs2 = 5'd7;
    #1;
    checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("[TB] FAIL waw_reissued_busy: got %b want 0", bus.iss_ready); end
    idleInputs();
  endtask

  task automatic test_reset_mid_write();
    test_reset();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    nextCycle();
    bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99990009;
    nextCycle();
    bus.alu_valid = 1'b0; bus.iss_rs1 = 5'd9;
    #1;
    checks++; if (bus.rf_wen !== 1'b1 || bus.iss_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pre: got wen=%b iss_ready=%b want 1/0", bus.rf_wen, bus.iss_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rf_wen !== 1'b0) begin errors++; $display("[TB] FAIL midrst_async_wen: got %b want 0", bus.rf_wen); end
    checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy_cleared: got %b want 1", bus.iss_ready); end
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    bus.iss_valid = 1'b1;
    #1;
    checks++; if (bus.iss_ready !== 1'b1 || bus.rf_wen !== 1'b0) begin errors++; $display("[TB] FAIL midrst_after: got iss_ready=%b wen=%b want 1/0", bus.iss_ready, bus.rf_wen); end
    nextCycle();
    idleInputs();
  endtask

  // Run every scenario in sequence, then report.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_raw();
    test_conflict();
    test_x0();
    test_waw();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Write-back scheduler and hazard scoreboard for the 2-read/1-write integer register file. It arbitrates the single write port between the ALU and LSU result streams and keeps one busy bit per architectural register. Decode is stalled on any RAW/WAW hazard. It sits between execute/LSU and the register file, driving the file's `wen`/`rd`/`wdata` and gating instruction issue.

## Interface
- `ADDR_WIDTH`, 5, register index width (2**ADDR_WIDTH registers)
- `DATA_WIDTH`, 32, write data width

- `clk` in 1: single clock, all state on posedge
- `rst_n` in 1: asynchronous, active-low reset
- `iss_valid` in 1: decode presents an instruction
- `iss_rs1` in ADDR_WIDTH: source 1 index
- `iss_rs2` in ADDR_WIDTH: source 2 index
- `iss_rd` in ADDR_WIDTH: destination index (0 = no write)
- `iss_ready` out 1: no hazard; issue accepted when `iss_valid & iss_ready`
- `alu_valid` in 1: ALU result pending
- `alu_rd` in ADDR_WIDTH: ALU destination
- `alu_data` in DATA_WIDTH: ALU result
- `alu_ready` out 1: ALU result granted this cycle
- `lsu_valid` in 1: load result pending
- `lsu_rd` in ADDR_WIDTH: load destination
- `lsu_data` in DATA_WIDTH: load data
- `lsu_ready` out 1: load result granted this cycle
- `rf_wen` out 1: register file write enable
- `rf_rd` out ADDR_WIDTH: register file write index
- `rf_wdata` out DATA_WIDTH: register file write data

## Operation
- State:
  - `busy[2**ADDR_WIDTH-1:0]`
  - `last_grant` (0=ALU, 1=LSU)
  - Registered write port `rf_wen`/`rf_rd`/`rf_wdata`
- Reset:
  - All busy bits cleared.
  - `last_grant`=1 (LSU), so the ALU wins the first tie.
  - `rf_wen`=0, `rf_rd`=0, `rf_wdata`=0.
- Hazard:
  - `hazard = busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]`.
  - `iss_ready = ~hazard`, combinational from registered state only.
  - `busy[0]` is hard-wired 0.
  - After reset, `iss_ready`=1.
- Issue: on `iss_valid & iss_ready & (iss_rd != 0)`, set `busy[iss_rd]` at the clock edge.
- Arbitration:
  - Only one source valid: that source is granted.
  - Both valid: grant the source not named by `last_grant`.
  - `last_grant` updates only on a grant.
  - `*_ready` is 0 whenever the matching `*_valid` is 0.
  - Requesters must hold `valid`, `rd` and `data` stable until ready.
- Write port:
  - A granted request registers into `rf_rd`/`rf_wdata` on the next edge.
  - `rf_wen` is set to 1 at that edge if `rd != 0`, else 0 (an x0 write is consumed but suppressed).
  - With no grant, `rf_wen` goes 0 and `rf_rd`/`rf_wdata` hold their values.
- Busy clear:
  - At every edge where `rf_wen`=1, clear `busy[rf_rd]`.
  - Writing a register that is not busy is legal: the data is written and the clear is a no-op.
- Simultaneous set and clear on the same index: set wins. This is unreachable in legal operation because the WAW check blocks it.
- Async reset mid-operation:
  - Abandons any in-flight write (`rf_wen` drops immediately).
  - Clears all busy bits.
  - Upstream must also be reset.

## Timing
- Grant in cycle N → `rf_wen`=1 in cycle N+1 → register file updated and busy bit cleared at the end of N+1. A dependent instruction sees `iss_ready`=1 in N+2.
- Issue in cycle N → busy visible from N+1 (`iss_ready` low for a dependent instruction in N+1).
- Throughput: one write per cycle. With both sources continuously valid, grants alternate every cycle.
- No combinational path from `*_data` to any output; `*_ready` depends on `*_valid` and `last_grant`.

## Configuration
- `RF_WB_RR_ARB_EN`
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, LSU always beats ALU when both are valid. `last_grant` is still maintained but ignored. Reset values are unchanged.

## Test plan
- Reset then idle:
  - During and after `rst_n`=0 → `rf_wen`=0, `iss_ready`=1, `alu_ready`=`lsu_ready`=0.
- RAW stall:
  - Issue `iss_rd`=5 at cycle 0, then present rs1=5 from cycle 1 → `iss_ready`=0.
  - ALU writes rd=5, data 0xDEADBEEF, at cycle 3 → `rf_wen`=1, `rf_rd`=5 in cycle 4; `iss_ready`=1 in cycle 5.
- Conflict:
  - ALU (rd=3) and LSU (rd=4) both valid for 2 cycles with the macro defined → grants ALU then LSU; `rf_rd`=3 then 4.
  - Without the macro → LSU first.
- x0:
  - Issue rd=0 → no busy bit set.
  - ALU write with rd=0, data 0x1234 → `alu_ready`=1, `rf_wen` stays 0.
- WAW:
  - rd=7 busy, issue another instruction with rd=7 → `iss_ready`=0 until the LSU write to 7 has appeared on `rf_wen`.
- Reset mid-write:
  - Assert `rst_n`=0 while `rf_wen`=1 and `busy[9]`=1 → `rf_wen`=0 asynchronously; after release, rs1=9 issues with `iss_ready`=1.
